param_core: RTL and testbench
=============================

PARAM_CORE -- requirements
Module: param_core

Interface
REQ-001 Parameter DATA_W, default 32: datapath, register and data-memory word width, minimum 8.
REQ-002 Parameter PC_W, default 6: program counter width, range 1..8.
REQ-003 Parameter ADDR_W, default 12: data-memory address width, at most DATA_W.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port imem_req, output, 1: instruction fetch request.
REQ-007 Port imem_addr, output, PC_W: fetch address, equal to the PC.
REQ-008 Port imem_ack, input, 1: fetch complete; imem_rdata is valid in the same cycle.
REQ-009 Port imem_rdata, input, 20: instruction word.
REQ-010 Port dmem_req, output, 1: data access request.
REQ-011 Port dmem_we, output, 1: 1 = store, 0 = load; valid while dmem_req is high.
REQ-012 Port dmem_addr, output, ADDR_W: data address.
REQ-013 Port dmem_wdata, output, DATA_W: store data.
REQ-014 Port dmem_ack, input, 1: data access complete; dmem_rdata is valid in the same cycle.
REQ-015 Port dmem_rdata, input, DATA_W: load data.
REQ-016 Port halted, output, 1: core is in the HALT state.

Function
REQ-017 Instruction encoding: opcode[19:16], rd[15:12], ra[11:8], rb[7:4], imm8[7:0] (imm8 overlaps rb); 16 general registers, all writable.
REQ-018 Opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= ra op rb, modulo 2^DATA_W.
- 6 LDI: rd <= zero-extended imm8.
- 7 LD: rd <= mem[ra[ADDR_W-1:0]].
- 8 ST: mem[ra[ADDR_W-1:0]] <= rb.
- 9 JMP: PC <= imm8[PC_W-1:0].
- A JZ: jump if Z = 1, otherwise PC + 1.
- B HALT.
- C MUL (see Configuration).
- D-F illegal, executed as NOP.
REQ-019 FSM states and transitions:
- IDLE -> FETCH.
- FETCH -> DECODE on imem_ack; stays in FETCH otherwise.
- DECODE -> EXEC.
- EXEC -> MEM for LD/ST; -> HALT for HALT; -> FETCH for NOP, JMP, JZ and illegal opcodes; -> WB otherwise.
- MEM -> WB (LD) or FETCH (ST) on dmem_ack; stays in MEM otherwise.
- WB -> FETCH.
- HALT is sticky until reset.
REQ-020 imem_req is 1 only in FETCH and dmem_req is 1 only in MEM, both decoded from the registered state; address and data are held stable until ack.
REQ-021 Ack on an input whose req is low is ignored.
REQ-022 The IR latches imem_rdata on the imem_ack edge.
REQ-023 The PC updates in EXEC only: PC + 1 modulo 2^PC_W (wrap from 2^PC_W-1 to 0), or the jump target.
REQ-024 The Z flag updates only on ADD/SUB/AND/OR/XOR/MUL: Z = (result == 0); Z is otherwise held.
REQ-025 Latency with zero-wait acks:
- ALU, LDI, MUL: 4 cycles.
- NOP, JMP, JZ: 3 cycles.
- ST: 4 cycles.
- LD: 5 cycles.
- Each wait cycle adds 1.
REQ-026 A register read in DECODE sees the WB write of the previous instruction; no bypass is needed.

Reset
REQ-027 While rst_n = 0, the following are 0 immediately and independently of clk: state = IDLE, PC, IR, Z, all 16 registers, imem_req, dmem_req, dmem_we, halted, dmem_addr and dmem_wdata.
REQ-028 Reset asserted mid-FETCH or mid-MEM aborts the access; the core does not complete the access, and no register write occurs.
REQ-029 After rst_n rises, the core spends 1 cycle in IDLE and then fetches from address 0.

Configuration
REQ-030 With macro PARAM_CORE_MUL_EN defined, opcode C computes rd <= low DATA_W bits of ra*rb in a single EXEC cycle and updates Z.
REQ-031 Without PARAM_CORE_MUL_EN, opcode C is illegal: NOP behaviour, no multiplier is synthesised, and Z is unchanged.

Structure
REQ-032 Shared package param_core_pkg holds the opcode enum, the FSM state enum, instruction field position constants and the IR width constant 20.
REQ-033 Sub-module core_alu is combinational: operands a and b, DATA_W wide; op, 4 bits; result; zero.

Verification
REQ-034 Reset: hold rst_n low for 3 cycles during a FETCH with imem_ack = 1 -> all outputs 0; on release, imem_req rises 2 cycles later with imem_addr = 0.
REQ-035 Arithmetic and Z:
- LDI r1,5; LDI r2,5; SUB r3,r1,r2 -> r3 = 0, Z = 1.
- ADD r4,r1,r2 -> r4 = 10, Z = 0.
- LDI r5,255; then ADD r5,r5,r5 with DATA_W = 8 -> r5 = 0xFE (modulo 256), Z = 0.
REQ-036 Handshake: withhold imem_ack for 3 cycles, then withhold dmem_ack for 2 cycles on LD r6,[r1] with mem[5] = 0xDEADBEEF:
- imem_addr and dmem_addr are stable throughout.
- r6 = 0xDEADBEEF.
- Total latency is 10 cycles.
REQ-037 Branch and wrap:
- PC_W = 6: NOP at address 63 -> next fetch at address 0.
- JZ 0x2A with Z = 1 -> next fetch at 0x2A; with Z = 0 -> next fetch at PC + 1.
REQ-038 Store: ST [r1],r4 -> dmem_req = 1, dmem_we = 1, dmem_addr = 5, dmem_wdata = 10 until ack; no register changes.
REQ-039 MUL and HALT:
- MUL r7,r1,r2 gives r7 = 25 with PARAM_CORE_MUL_EN defined; r7 is unchanged and the PC advances without it.
- HALT -> halted = 1, and imem_req stays 0 for 20 cycles.

Source files
------------

// File: rtl/param_core_pkg.sv
// -----------------------------------------------------------------------------
// param_core_pkg
// Shared definitions for the param_core multi-cycle processor:
//   - instruction word width and field positions
//   - opcode enumeration
//   - control FSM state enumeration
//   - helper deciding which opcodes produce an ALU result and update Z
// Optional feature macro: PARAM_CORE_MUL_EN (opcode C becomes MUL).
// -----------------------------------------------------------------------------
package param_core_pkg;

    localparam int IR_W    = 20;
    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_HALT = 4'hB,
        OP_MUL  = 4'hC
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    // Opcodes whose result comes from core_alu and that update the Z flag.
    function automatic logic is_alu_op(input opcode_e op);
        logic hit;
        hit = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
              (op == OP_OR)  || (op == OP_XOR);
`ifdef PARAM_CORE_MUL_EN
        hit = hit || (op == OP_MUL);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/param_core_alu.sv
// -----------------------------------------------------------------------------
// core_alu
// Purely combinational ALU for param_core.
// Ports:
//   a, b   : DATA_W operands
//   op     : 4-bit opcode (ADD/SUB/AND/OR/XOR, MUL when PARAM_CORE_MUL_EN)
//   result : DATA_W result, modulo 2^DATA_W
//   zero   : result == 0
// Optional feature macro: PARAM_CORE_MUL_EN. Without it no multiplier exists.
// -----------------------------------------------------------------------------
module core_alu
    import param_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned and no latch is inferred.
        result = '0;
        unique case (opcode_e'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
`ifdef PARAM_CORE_MUL_EN
            OP_MUL:  result = a * b;
`endif
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/param_core.sv
// -----------------------------------------------------------------------------
// param_core
// Small multi-cycle load/store processor with a 16 x DATA_W register file,
// handshaked instruction and data memory ports, and a Z flag.
// FSM: IDLE -> FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH, HALT}.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   imem_req/imem_addr              : fetch request, address = PC
//   imem_ack/imem_rdata             : fetch done, instruction word
//   dmem_req/dmem_we/dmem_addr/
//   dmem_wdata                      : data access request (we=1 store)
//   dmem_ack/dmem_rdata             : data access done, load data
//   halted                          : core is in HALT
// Optional feature macro: PARAM_CORE_MUL_EN (opcode C = MUL, else NOP).
// -----------------------------------------------------------------------------
module param_core
    import param_core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [IR_W-1:0]     ir_q;
    logic                z_q;
    logic [DATA_W-1:0]   regs_q [16];
    logic [DATA_W-1:0]   op_a_q, op_b_q, res_q;
    logic [ADDR_W-1:0]   dmem_addr_q;
    logic [DATA_W-1:0]   dmem_wdata_q;
    logic                dmem_we_q;

    opcode_e             opcode;
    logic [3:0]          rd, ra, rb;
    logic [7:0]          imm8;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    assign opcode = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
    assign rd     = ir_q[RD_MSB:RD_LSB];
    assign ra     = ir_q[RA_MSB:RA_LSB];
    assign rb     = ir_q[RB_MSB:RB_LSB];
    assign imm8   = ir_q[IMM_MSB:IMM_LSB];

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .op     (ir_q[OPC_MSB:OPC_LSB]),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Requests are decoded from the registered state only.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign halted     = (state_q == S_HALT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LD || opcode == OP_ST)          state_d = S_MEM;
                else if (opcode == OP_HALT)                      state_d = S_HALT;
                else if (opcode == OP_LDI || is_alu_op(opcode))  state_d = S_WB;
                else                                             state_d = S_FETCH;
            end
            S_MEM:    if (dmem_ack) state_d = (opcode == OP_LD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            ir_q         <= '0;
            z_q          <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: if (imem_ack) ir_q <= imem_rdata;
                S_DECODE: begin
                    op_a_q <= regs_q[ra];
                    op_b_q <= regs_q[rb];
                end
                S_EXEC: begin
                    if (opcode == OP_JMP || (opcode == OP_JZ && z_q))
                        pc_q <= imm8[PC_W-1:0];
                    else
                        pc_q <= pc_q + PC_W'(1);
                    if (is_alu_op(opcode)) z_q <= alu_zero;
                    res_q <= (opcode == OP_LDI) ? DATA_W'(imm8) : alu_result;
                    // Address/data/we are captured once and then held until ack.
                    if (opcode == OP_LD || opcode == OP_ST) begin
                        dmem_addr_q  <= op_a_q[ADDR_W-1:0];
                        dmem_wdata_q <= op_b_q;
                        dmem_we_q    <= (opcode == OP_ST);
                    end
                end
                S_MEM: if (dmem_ack && opcode == OP_LD) res_q <= dmem_rdata;
                default: ;
            endcase
        end
    end

    // NOTE: the register file is reset explicitly because software may read
    // any register before writing it; this rules out a RAM macro by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (state_q == S_WB) begin
            regs_q[rd] <= res_q;
        end
    end

endmodule

// File: tb/tb_param_core.sv
// -----------------------------------------------------------------------------
// tb_param_core
// Self-checking bench for param_core. Two instances share one clock/reset:
// a default build (DATA_W=32) and a DATA_W=8 build for the modulo-256 case.
// sel8 routes acks to one instance and selects which one is monitored.
// A bench-side model of registers, Z and PC predicts each instruction; memory
// accesses are predicted into a queue and popped when dmem_req appears.
// -----------------------------------------------------------------------------
module tb_param_core;

    localparam logic [3:0] O_NOP = 4'h0, O_ADD = 4'h1, O_SUB = 4'h2, O_AND = 4'h3,
                           O_OR  = 4'h4, O_XOR = 4'h5, O_LDI = 4'h6, O_LD  = 4'h7,
                           O_ST  = 4'h8, O_JMP = 4'h9, O_JZ  = 4'hA, O_HALT = 4'hB,
                           O_MUL = 4'hC;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel8;
    logic        imem_ack, dmem_ack;
    logic [19:0] imem_rdata;
    logic [31:0] dmem_rdata;

    logic        a_imem_req, a_dmem_req, a_dmem_we, a_halted;
    logic [5:0]  a_imem_addr;
    logic [11:0] a_dmem_addr;
    logic [31:0] a_dmem_wdata;
    logic        b_imem_req, b_dmem_req, b_dmem_we, b_halted;
    logic [5:0]  b_imem_addr;
    logic [7:0]  b_dmem_addr;
    logic [7:0]  b_dmem_wdata;

    logic        m_imem_req, m_dmem_req, m_dmem_we, m_halted;
    logic [5:0]  m_imem_addr;
    logic [11:0] m_dmem_addr;
    logic [31:0] m_dmem_wdata;

    logic [31:0] exp_regs [16];
    logic        exp_z;
    logic [5:0]  exp_pc;
    logic [31:0] dmask;
    logic [11:0] amask;
    mem_exp_t    mem_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    param_core #(.DATA_W(32), .PC_W(6), .ADDR_W(12)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(a_imem_req), .imem_addr(a_imem_addr),
        .imem_ack(imem_ack & ~sel8), .imem_rdata(imem_rdata),
        .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr),
        .dmem_wdata(a_dmem_wdata), .dmem_ack(dmem_ack & ~sel8),
        .dmem_rdata(dmem_rdata), .halted(a_halted)
    );

    param_core #(.DATA_W(8), .PC_W(6), .ADDR_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(imem_ack & sel8), .imem_rdata(imem_rdata),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr),
        .dmem_wdata(b_dmem_wdata), .dmem_ack(dmem_ack & sel8),
        .dmem_rdata(dmem_rdata[7:0]), .halted(b_halted)
    );

    assign m_imem_req   = sel8 ? b_imem_req   : a_imem_req;
    assign m_imem_addr  = sel8 ? b_imem_addr  : a_imem_addr;
    assign m_dmem_req   = sel8 ? b_dmem_req   : a_dmem_req;
    assign m_dmem_we    = sel8 ? b_dmem_we    : a_dmem_we;
    assign m_dmem_addr  = sel8 ? {4'h0, b_dmem_addr}   : a_dmem_addr;
    assign m_dmem_wdata = sel8 ? {24'h0, b_dmem_wdata} : a_dmem_wdata;
    assign m_halted     = sel8 ? b_halted     : a_halted;

    function automatic logic [19:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb);
        return {op, rd, ra, rb, 4'h0};
    endfunction

    function automatic logic [19:0] ins_i(input logic [3:0] op, input logic [3:0] rd,
                                          input logic [7:0] imm);
        return {op, rd, 4'h0, imm};
    endfunction

    task automatic model_init(input logic is8);
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        exp_z  = 1'b0;
        exp_pc = '0;
        dmask  = is8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        amask  = is8 ? 12'h0FF : 12'hFFF;
        mem_q.delete();
    endtask

    // Predicts one instruction: register/Z/PC effects, memory accesses, latency.
    task automatic model_instr(input logic [19:0] i, input logic [31:0] ld, output int base);
        logic [3:0]  op, rd, ra, rb;
        logic [7:0]  imm;
        logic [31:0] va, vb, r;
        logic [5:0]  npc;
        mem_exp_t    e;
        op = i[19:16]; rd = i[15:12]; ra = i[11:8]; rb = i[7:4]; imm = i[7:0];
        va = exp_regs[ra]; vb = exp_regs[rb];
        npc = exp_pc + 6'd1;
        base = 3;
        r = '0;
        case (op)
            O_ADD, O_SUB, O_AND, O_OR, O_XOR: begin
                case (op)
                    O_ADD:   r = va + vb;
                    O_SUB:   r = va - vb;
                    O_AND:   r = va & vb;
                    O_OR:    r = va | vb;
                    default: r = va ^ vb;
                endcase
                r = r & dmask;
                exp_regs[rd] = r; exp_z = (r == 0); base = 4;
            end
            O_LDI: begin exp_regs[rd] = {24'h0, imm} & dmask; base = 4; end
            O_LD: begin
                e.we = 1'b0; e.addr = va[11:0] & amask; e.wdata = '0;
                mem_q.push_back(e);
                exp_regs[rd] = ld & dmask; base = 5;
            end
            O_ST: begin
                e.we = 1'b1; e.addr = va[11:0] & amask; e.wdata = vb;
                mem_q.push_back(e);
                base = 4;
            end
            O_JMP: npc = imm[5:0];
            O_JZ:  if (exp_z) npc = imm[5:0];
`ifdef PARAM_CORE_MUL_EN
            O_MUL: begin
                r = (va * vb) & dmask;
                exp_regs[rd] = r; exp_z = (r == 0); base = 4;
            end
`endif
            default: ;
        endcase
        exp_pc = npc;
    endtask

    // Waits for a fetch, checks its address, serves it after iwait cycles,
    // serves any data access after dwait cycles, and checks the latency.
    task automatic do_instr(input string name, input logic [19:0] i, input int iwait,
                            input int dwait, input logic [31:0] ld);
        int          n, lat, base, exp_lat;
        logic [5:0]  a0;
        logic [11:0] da;
        logic [31:0] dd;
        logic        dwe;
        mem_exp_t    e;
        n = 0;
        while (!m_imem_req && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (m_imem_req !== 1'b1) begin
            failures++;
            $display("FAIL %s fetch_wait: imem_req=%b, expected 1 within 40 cycles", name, m_imem_req);
            return;
        end
        checks++;
        if (m_imem_addr !== exp_pc) begin
            failures++;
            $display("FAIL %s fetch_addr: got %0h expected %0h", name, m_imem_addr, exp_pc);
        end
        model_instr(i, ld, base);
        exp_lat = base + iwait + (((i[19:16] == O_LD) || (i[19:16] == O_ST)) ? dwait : 0);
        lat = 0;
        a0  = m_imem_addr;
        repeat (iwait) begin
            imem_ack = 1'b0;
            @(negedge clk); lat++;
            checks++;
            if (m_imem_req !== 1'b1 || m_imem_addr !== a0) begin
                failures++;
                $display("FAIL %s imem_hold: req=%b addr=%0h expected req=1 addr=%0h",
                         name, m_imem_req, m_imem_addr, a0);
            end
        end
        imem_rdata = i; imem_ack = 1'b1;
        @(negedge clk); lat++;
        imem_ack = 1'b0; imem_rdata = '0;
        n = 0;
        while (!m_imem_req && !m_halted && n < 40) begin
            n++;
            if (m_dmem_req) begin
                checks++;
                if (mem_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s dmem_unexpected: access we=%b addr=%0h, expected none",
                             name, m_dmem_we, m_dmem_addr);
                end else begin
                    e = mem_q.pop_front();
                    if (m_dmem_we !== e.we || m_dmem_addr !== e.addr ||
                        (e.we && m_dmem_wdata !== e.wdata)) begin
                        failures++;
                        $display("FAIL %s dmem_access: got we=%b addr=%0h wdata=%0h expected we=%b addr=%0h wdata=%0h",
                                 name, m_dmem_we, m_dmem_addr, m_dmem_wdata, e.we, e.addr, e.wdata);
                    end
                end
                da = m_dmem_addr; dd = m_dmem_wdata; dwe = m_dmem_we;
                repeat (dwait) begin
                    @(negedge clk); lat++;
                    checks++;
                    if (m_dmem_req !== 1'b1 || m_dmem_addr !== da || m_dmem_wdata !== dd ||
                        m_dmem_we !== dwe) begin
                        failures++;
                        $display("FAIL %s dmem_hold: req=%b we=%b addr=%0h wdata=%0h expected 1/%b/%0h/%0h",
                                 name, m_dmem_req, m_dmem_we, m_dmem_addr, m_dmem_wdata, dwe, da, dd);
                    end
                end
                dmem_rdata = ld; dmem_ack = 1'b1;
                @(negedge clk); lat++;
                dmem_ack = 1'b0; dmem_rdata = '0;
            end else begin
                @(negedge clk); lat++;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (mem_q.size() != 0) begin
            failures++;
            $display("FAIL %s dmem_missing: %0d predicted accesses not seen, expected 0", name, mem_q.size());
            mem_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({m_imem_req, m_imem_addr, m_dmem_req, m_dmem_we, m_dmem_addr, m_dmem_wdata, m_halted} !== '0) begin
            failures++;
            $display("FAIL %s outputs_in_reset: req=%b ia=%0h dreq=%b we=%b da=%0h wd=%0h halted=%b, expected all 0",
                     name, m_imem_req, m_imem_addr, m_dmem_req, m_dmem_we, m_dmem_addr, m_dmem_wdata, m_halted);
        end
    endtask

    // Release reset just after a rising edge: one IDLE cycle, then fetch at 0.
    task automatic release_reset(input string name, input logic is8);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_imem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_cycle: imem_req=%b expected 0", name, m_imem_req);
        end
        @(negedge clk);
        checks++;
        if (m_imem_req !== 1'b1 || m_imem_addr !== 6'd0) begin
            failures++;
            $display("FAIL %s first_fetch: req=%b addr=%0h expected req=1 addr=0", name, m_imem_req, m_imem_addr);
        end
        model_init(is8);
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0; sel8 = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        while (!m_imem_req && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (m_imem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset pre_fetch: imem_req=%b expected 1", m_imem_req);
        end
        // Reset lands in the middle of an acknowledged fetch.
        imem_rdata = ins_i(O_LDI, 4'h1, 8'h77); imem_ack = 1'b1;
        rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        imem_ack = 1'b0; imem_rdata = '0;
        release_reset("reset", 1'b0);
    endtask

    task automatic test_arith;
        do_instr("ldi_r1",  ins_i(O_LDI, 4'h1, 8'd5), 0, 0, '0);
        do_instr("ldi_r2",  ins_i(O_LDI, 4'h2, 8'd5), 0, 0, '0);
        do_instr("sub_r3",  ins(O_SUB, 4'h3, 4'h1, 4'h2), 0, 0, '0);
        do_instr("jz_z1",   ins_i(O_JZ, 4'h0, 8'h06), 0, 0, '0);
        do_instr("st_r3",   ins(O_ST, 4'h0, 4'h1, 4'h3), 0, 0, '0);
        do_instr("add_r4",  ins(O_ADD, 4'h4, 4'h1, 4'h2), 0, 0, '0);
        do_instr("jz_z0",   ins_i(O_JZ, 4'h0, 8'h2A), 0, 0, '0);
    endtask

    task automatic test_store;
        do_instr("st_r4_wait", ins(O_ST, 4'h0, 4'h1, 4'h4), 0, 2, '0);
    endtask

    task automatic test_handshake;
        do_instr("ld_r6_wait", ins(O_LD, 4'h6, 4'h1, 4'h0), 3, 2, 32'hDEAD_BEEF);
        do_instr("st_r6",      ins(O_ST, 4'h0, 4'h2, 4'h6), 0, 0, '0);
    endtask

    task automatic test_mul;
        do_instr("sub_z1",  ins(O_SUB, 4'h3, 4'h1, 4'h2), 0, 0, '0);
        do_instr("mul_r7",  ins(O_MUL, 4'h7, 4'h1, 4'h2), 0, 0, '0);
        do_instr("jz_mul",  ins_i(O_JZ, 4'h0, 8'h14), 0, 0, '0);
        do_instr("st_r7",   ins(O_ST, 4'h0, 4'h0, 4'h7), 0, 0, '0);
        do_instr("illegal", ins(4'hE, 4'h1, 4'h2, 4'h2), 0, 0, '0);
        do_instr("st_r1",   ins(O_ST, 4'h0, 4'h1, 4'h1), 0, 0, '0);
    endtask

    task automatic test_logic;
        do_instr("ldi_r8",  ins_i(O_LDI, 4'h8, 8'h0C), 0, 0, '0);
        do_instr("and_r9",  ins(O_AND, 4'h9, 4'h8, 4'h1), 0, 0, '0);
        do_instr("or_r10",  ins(O_OR,  4'hA, 4'h8, 4'h1), 0, 0, '0);
        do_instr("xor_r11", ins(O_XOR, 4'hB, 4'h8, 4'h8), 0, 0, '0);
        do_instr("st_r9",   ins(O_ST, 4'h0, 4'h1, 4'h9), 0, 0, '0);
        do_instr("st_r10",  ins(O_ST, 4'h0, 4'h8, 4'hA), 0, 0, '0);
    endtask

    task automatic test_branch;
        do_instr("jmp_63",  ins_i(O_JMP, 4'h0, 8'h3F), 0, 0, '0);
        do_instr("nop_63",  ins(O_NOP, 4'h0, 4'h0, 4'h0), 0, 0, '0);
        do_instr("sub_z1b", ins(O_SUB, 4'h3, 4'h1, 4'h2), 0, 0, '0);
        do_instr("jz_2a",   ins_i(O_JZ, 4'h0, 8'h2A), 0, 0, '0);
        do_instr("add_z0",  ins(O_ADD, 4'h4, 4'h1, 4'h2), 0, 0, '0);
        do_instr("jz_nt",   ins_i(O_JZ, 4'h0, 8'h10), 0, 0, '0);
    endtask

    task automatic test_halt;
        do_instr("halt", ins(O_HALT, 4'h0, 4'h0, 4'h0), 0, 0, '0);
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (m_halted !== 1'b1 || m_imem_req !== 1'b0) begin
                failures++;
                $display("FAIL halt_sticky: halted=%b imem_req=%b expected 1/0", m_halted, m_imem_req);
            end
        end
    endtask

    task automatic test_wrap8;
        rst_n = 1'b0;
        #1 check_all_zero("reset_after_halt");
        sel8 = 1'b1;
        release_reset("reset8", 1'b1);
        do_instr("w8_ldi",  ins_i(O_LDI, 4'h5, 8'hFF), 0, 0, '0);
        do_instr("w8_add",  ins(O_ADD, 4'h5, 4'h5, 4'h5), 0, 0, '0);
        do_instr("w8_st",   ins(O_ST, 4'h0, 4'h0, 4'h5), 0, 0, '0);
        do_instr("w8_jz",   ins_i(O_JZ, 4'h0, 8'h2A), 0, 0, '0);
        do_instr("w8_nop",  ins(O_NOP, 4'h0, 4'h0, 4'h0), 0, 0, '0);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_store();
        test_handshake();
        test_mul();
        test_logic();
        test_branch();
        test_halt();
        test_wrap8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
